// File: rtl/phy_lanes_p_if.sv
// Parallel-side bus of phy_lanes_p: tx word handshake plus rx word delivery.
// The PHY connects through the slave modport, the user logic through master.
interface phy_lanes_p_if #(
    parameter int DATA_W = 32
);
    logic              valid_in;
    logic [DATA_W-1:0] Data_in;
    logic              ready_out;
    logic              valid_out_c;
    logic [DATA_W-1:0] Data_out_c;
    logic              rx_active;

    modport master (
        output valid_in, Data_in,
        input  ready_out, valid_out_c, Data_out_c, rx_active
    );

    modport slave (
        input  valid_in, Data_in,
        output ready_out, valid_out_c, Data_out_c, rx_active
    );
endinterface

// File: rtl/phy_lanes_p.sv
// phy_lanes_p: multi-lane serializer/deserializer with IDLE-based word lock.
// Tx splits each DATA_W word over LANES serial lanes (BITS = DATA_W/LANES
// bits per lane, MSB first); empty slots carry the IDLE pattern 0xBC...BC.
// Rx shifts every lane each edge, hunts for IDLE to find the word phase,
// confirms SYNC_N aligned IDLE words, then delivers every non-IDLE word.
// Optional feature: define PHY_LOOPBACK_EN to feed rx from the tx lane
// registers instead of Data_in_lanes.
module phy_lanes_p #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int SYNC_N = 4     // 1..15, fits the 4-bit idle counter
) (
    input  logic              clk_32f,
    input  logic              reset,
    phy_lanes_p_if.slave      bus,
    output logic [LANES-1:0]  Data_out_lanes,
    input  logic [LANES-1:0]  Data_in_lanes
);
    localparam int                BITS = DATA_W / LANES;
    localparam int                CW   = $clog2(BITS);
    localparam logic [CW-1:0]     LAST = CW'(BITS - 1);
    localparam logic [DATA_W-1:0] IDLE = {(DATA_W / 8){8'hBC}};

    typedef enum logic [1:0] {SYNC, ALIGN, ACTIVE} rx_state_e;

    // ---------------------------------------------------------------- tx
    logic [CW-1:0]              tx_cnt_q;
    logic [LANES-1:0][BITS-1:0] tx_sh_q;
    logic                       tx_load;
    logic [DATA_W-1:0]          tx_word;

    // The last slot position is the only edge where a new word is loaded.
    assign tx_load       = (tx_cnt_q == LAST);
    assign bus.ready_out = tx_load;
    assign tx_word       = (bus.valid_in && tx_load) ? bus.Data_in : IDLE;

    // Slot counter and per-lane shift registers; lane k gets word[k*BITS +: BITS].
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            tx_cnt_q <= '0;
            tx_sh_q  <= '0;
        end else begin
            tx_cnt_q <= tx_load ? '0 : tx_cnt_q + 1'b1;
            if (tx_load) begin
                tx_sh_q <= tx_word;
            end else begin
                for (int k = 0; k < LANES; k++) begin
                    tx_sh_q[k] <= {tx_sh_q[k][BITS-2:0], 1'b0};
                end
            end
        end
    end

    // Each lane pin is the MSB flop of its shift register, so no glitches.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign Data_out_lanes[k] = tx_sh_q[k][BITS-1];
    end

    // ---------------------------------------------------------------- rx
    logic [LANES-1:0] rx_lanes;

`ifdef PHY_LOOPBACK_EN
    logic unused_rx_in;
    assign rx_lanes     = Data_out_lanes;
    assign unused_rx_in = ^Data_in_lanes;
`else
    assign rx_lanes = Data_in_lanes;
`endif

    logic [LANES-1:0][BITS-1:0] rx_sh_q;
    logic [DATA_W-1:0]          rx_word;
    logic                       rx_idle;

    assign rx_word = rx_sh_q;
    assign rx_idle = (rx_word == IDLE);

    // Deserializer: every lane shifts in one bit per edge, oldest bit ends up at the MSB.
    // NOTE: these shift registers are reset on purpose so a reset mid-word
    // cannot leave stale bits that later assemble into a partial word.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            rx_sh_q <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                rx_sh_q[k] <= {rx_sh_q[k][BITS-2:0], rx_lanes[k]};
            end
        end
    end

    rx_state_e         state_q, state_d;
    logic [CW-1:0]     phase_q, phase_d;
    logic [3:0]        idle_cnt_q, idle_cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              boundary;

    // phase_q == LAST means the shift registers hold a complete aligned word.
    assign boundary = (phase_q == LAST);

    // Lock FSM next state: hunt any-phase in SYNC, then judge whole words only.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = boundary ? '0 : phase_q + 1'b1;
        idle_cnt_d = idle_cnt_q;
        valid_d    = 1'b0;
        dout_d     = dout_q;
        unique case (state_q)
            SYNC: begin
                if (rx_idle) begin
                    phase_d    = '0;
                    idle_cnt_d = 4'd1;
                    state_d    = (SYNC_N == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (rx_idle) begin
                        idle_cnt_d = idle_cnt_q + 4'd1;
                        if (idle_cnt_d == 4'(SYNC_N)) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        idle_cnt_d = '0;
                        state_d    = SYNC;
                    end
                end
            end
            ACTIVE: begin
                // A data word equal to IDLE is indistinguishable and is dropped.
                if (boundary && !rx_idle) begin
                    valid_d = 1'b1;
                    dout_d  = rx_word;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Lock FSM registers and the registered rx word outputs.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q    <= SYNC;
            phase_q    <= '0;
            idle_cnt_q <= '0;
            valid_q    <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idle_cnt_q <= idle_cnt_d;
            valid_q    <= valid_d;
            dout_q     <= dout_d;
        end
    end

    assign bus.valid_out_c = valid_q;
    assign bus.Data_out_c  = dout_q;
    assign bus.rx_active   = (state_q == ACTIVE);
endmodule

// File: tb/tb_phy_lanes_p.sv
// Directed bench for phy_lanes_p at default parameters (32 bits, 2 lanes,
// SYNC_N = 4). Loopback is done in the bench (Data_in_lanes = Data_out_lanes)
// unless ext_mode selects a hand-built serial stream.
module tb_phy_lanes_p;
    localparam int          BITS   = 16;
    localparam logic [31:0] IDLE_W = 32'hBCBCBCBC;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic [1:0]  Data_out_lanes;
    logic [1:0]  Data_in_lanes;
    logic [1:0]  ext_lanes = 2'b00;
    logic        ext_mode  = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    phy_lanes_p_if #(.DATA_W(32)) bus ();

    phy_lanes_p #(.DATA_W(32), .LANES(2), .SYNC_N(4)) dut (
        .clk_32f        (clk_32f),
        .reset          (reset),
        .bus            (bus),
        .Data_out_lanes (Data_out_lanes),
        .Data_in_lanes  (Data_in_lanes)
    );

    assign Data_in_lanes = ext_mode ? ext_lanes : Data_out_lanes;

    always #5 clk_32f = ~clk_32f;
    always @(posedge clk_32f) cyc = cyc + 1;

    // Serial stream for the external test: 21 zero bits (word phase offset
    // 5 from the tx slot), then IDLE words, with word index 5 = 0xCAFEF00D.
    function automatic logic [1:0] stream_bits(input int t);
        logic [31:0] w;
        int idx;
        int j;
        if (t < 21) return 2'b00;
        idx = t - 21;
        j   = idx % 16;
        w   = (idx / 16 == 5) ? 32'hCAFEF00D : IDLE_W;
        return {w[16 + 15 - j], w[15 - j]};
    endfunction

    // Called at a negedge; returns at the first negedge with ready_out high.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.ready_out === 1'b1) ok = 1'b1;
            else begin
                @(posedge clk_32f);
                @(negedge clk_32f);
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_ready: ready_out never seen within 40 cycles");
        end
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0;
        bus.Data_in  = '0;
        reset        = 1'b0;
        repeat (3) @(negedge clk_32f);
        total++; if (Data_out_lanes !== 2'b00) begin bad++; $display("FAIL reset_lanes: got %b want 00", Data_out_lanes); end
        total++; if (bus.ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.ready_out); end
        total++; if (bus.valid_out_c !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_out_c); end
        total++; if (bus.Data_out_c !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.Data_out_c); end
        total++; if (bus.rx_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", bus.rx_active); end
    endtask

    // Releases reset at a negedge and expects lock within (4+2)*16 = 96 cycles.
    task automatic test_lock();
        int lock_n    = 0;
        int pulses    = 0;
        int ready_err = 0;
        reset = 1'b1;
        for (int n = 1; n <= 96 && lock_n == 0; n++) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            if (bus.valid_out_c === 1'b1) pulses++;
            // after edge n the slot counter is n mod 16; ready only at 15
            if (bus.ready_out !== ((n % 16) == 15)) ready_err++;
            if (bus.rx_active === 1'b1) lock_n = n;
        end
        total++; if (lock_n == 0) begin bad++; $display("FAIL lock_time: rx_active=%b after 96 cycles, want 1", bus.rx_active); end
        total++; if (pulses != 0) begin bad++; $display("FAIL lock_no_pulse: got %0d pulses want 0", pulses); end
        total++; if (ready_err != 0) begin bad++; $display("FAIL ready_phase: %0d cycles wrong, want 0", ready_err); end
    endtask

    task automatic test_single();
        bit          ok;
        int          acc;
        int          pcyc   = 0;
        int          pulses = 0;
        logic [31:0] pdata  = '0;
        wait_ready(ok);
        bus.valid_in = 1'b1;
        bus.Data_in  = 32'hDEADBEEF;
        acc = cyc + 1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            if (n == 1) bus.valid_in = 1'b0;
            if (bus.valid_out_c === 1'b1) begin
                pulses++;
                pcyc  = cyc;
                pdata = bus.Data_out_c;
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL single_count: got %0d pulses want 1", pulses); end
        total++; if (pcyc - acc != 17) begin bad++; $display("FAIL single_latency: got %0d want 17", pcyc - acc); end
        total++; if (pdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", pdata); end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          sent   = 0;
        int          npulse = 0;
        int          first_acc = 0;
        int          pc[4];
        logic [31:0] pd[4];
        for (int i = 0; i < 4; i++) begin pc[i] = 0; pd[i] = '0; end
        wait_ready(ok);
        for (int n = 0; n < 120; n++) begin
            if (bus.ready_out === 1'b1 && sent < 4) begin
                bus.valid_in = 1'b1;
                bus.Data_in  = 32'(sent + 1);
                if (sent == 0) first_acc = cyc + 1;
                sent++;
            end else if (bus.ready_out === 1'b1) begin
                bus.valid_in = 1'b0;
            end
            @(posedge clk_32f);
            @(negedge clk_32f);
            if (bus.valid_out_c === 1'b1) begin
                if (npulse < 4) begin
                    pc[npulse] = cyc;
                    pd[npulse] = bus.Data_out_c;
                end
                npulse++;
            end
        end
        bus.valid_in = 1'b0;
        total++; if (npulse != 4) begin bad++; $display("FAIL b2b_count: got %0d pulses want 4", npulse); end
        total++; if (pc[0] - first_acc != 17) begin bad++; $display("FAIL b2b_latency: got %0d want 17", pc[0] - first_acc); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pd[i] !== 32'(i + 1)) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, pd[i], 32'(i + 1)); end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (pc[i] - pc[i-1] != BITS) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 16", i, pc[i] - pc[i-1]); end
        end
    endtask

    // Runs after back-to-back, so Data_out_c must still hold word 4.
    task automatic test_idle_word();
        bit ok;
        int pulses = 0;
        wait_ready(ok);
        bus.valid_in = 1'b1;
        bus.Data_in  = IDLE_W;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            if (n == 1) bus.valid_in = 1'b0;
            if (bus.valid_out_c === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL idle_word_pulse: got %0d pulses want 0", pulses); end
        total++; if (bus.Data_out_c !== 32'h4) begin bad++; $display("FAIL idle_word_hold: got %h want 00000004", bus.Data_out_c); end
    endtask

    task automatic test_midword_reset();
        bit ok;
        int pulses = 0;
        wait_ready(ok);
        bus.valid_in = 1'b1;
        bus.Data_in  = 32'h13579BDF;
        @(posedge clk_32f);
        @(negedge clk_32f);
        bus.valid_in = 1'b0;
        repeat (8) @(posedge clk_32f);
        #2 reset = 1'b0;
        #1;
        total++; if (Data_out_lanes !== 2'b00) begin bad++; $display("FAIL mid_reset_lanes: got %b want 00", Data_out_lanes); end
        total++; if (bus.ready_out !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: got %b want 0", bus.ready_out); end
        total++; if (bus.valid_out_c !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", bus.valid_out_c); end
        total++; if (bus.Data_out_c !== 32'h0) begin bad++; $display("FAIL mid_reset_data: got %h want 0", bus.Data_out_c); end
        total++; if (bus.rx_active !== 1'b0) begin bad++; $display("FAIL mid_reset_active: got %b want 0", bus.rx_active); end
        repeat (2) @(negedge clk_32f);
        test_lock();
        for (int n = 0; n < 40; n++) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            if (bus.valid_out_c === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL relock_no_pulse: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_external();
        int          pulses = 0;
        int          prel   = 0;
        int          c0;
        logic [31:0] pdata  = '0;
        reset     = 1'b0;
        ext_mode  = 1'b1;
        ext_lanes = 2'b00;
        repeat (2) @(negedge clk_32f);
        reset     = 1'b1;
        c0        = cyc;
        ext_lanes = stream_bits(0);
        for (int t = 1; t <= 160; t++) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            if (bus.valid_out_c === 1'b1) begin
                pulses++;
                prel  = cyc - c0;
                pdata = bus.Data_out_c;
            end
            ext_lanes = stream_bits(t);
        end
        total++; if (bus.rx_active !== 1'b1) begin bad++; $display("FAIL ext_lock: got %b want 1", bus.rx_active); end
        total++; if (pulses != 1) begin bad++; $display("FAIL ext_count: got %0d pulses want 1", pulses); end
        total++; if (pdata !== 32'hCAFEF00D) begin bad++; $display("FAIL ext_data: got %h want cafef00d", pdata); end
        total++; if (prel != 118) begin bad++; $display("FAIL ext_when: got cycle %0d want 118", prel); end
        ext_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single();
        test_back_to_back();
        test_idle_word();
        test_midword_reset();
`ifndef PHY_LOOPBACK_EN
        test_external();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phy_lanes_p.md
PHY_LANES_P -- requirements
Module: phy_lanes_p

Interface
REQ-001 Parameter DATA_W, default 32: parallel word width; multiple of 8 and of LANES.
REQ-002 Parameter LANES, default 2: number of 1-bit serial lanes; BITS = DATA_W/LANES, with BITS >= 2.
REQ-003 Parameter SYNC_N, default 4: consecutive aligned IDLE words needed for rx lock; range 1..15.
REQ-004 clk_32f  input  1  single clock, one serial bit per lane per edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  tx word valid.
REQ-007 Data_in  input  DATA_W  tx word.
REQ-008 ready_out  output  1  tx accepts Data_in this cycle.
REQ-009 Data_out_lanes  output  LANES  serial tx lanes.
REQ-010 Data_in_lanes  input  LANES  serial rx lanes.
REQ-011 valid_out_c  output  1  rx word valid, one-cycle pulse.
REQ-012 Data_out_c  output  DATA_W  rx word.
REQ-013 rx_active  output  1  rx locked (ACTIVE state).

Function
REQ-014 IDLE pattern: DATA_W/8 copies of 8'hBC.
REQ-015 Tx slot counter: 0..BITS-1, free-running, wraps to 0; ready_out = 1 only when the counter is at BITS-1.
REQ-016 Transfer: valid_in && ready_out at an edge loads Data_in; otherwise that edge loads IDLE; no backpressure beyond ready_out.
REQ-017 Lane k carries Data[k*BITS +: BITS], MSB first; each lane output is driven from a register; bit 0 of the slot is visible after the load edge.
REQ-018 Rx samples Data_in_lanes every edge into per-lane shift registers; the assembled word uses the same lane mapping as tx.
REQ-019 Rx FSM SYNC: compare the assembled word with IDLE every cycle; on a match, zero the phase counter, set idle_cnt=1 and go to ALIGN.
REQ-020 Rx FSM ALIGN: evaluate only at phase boundaries (every BITS samples).
  - IDLE increments idle_cnt.
  - idle_cnt reaching SYNC_N goes to ACTIVE.
  - A non-IDLE word returns to SYNC and clears idle_cnt.
REQ-021 Rx FSM ACTIVE: at each boundary, a non-IDLE word is registered to Data_out_c and valid_out_c pulses for one cycle; an IDLE word produces no pulse and Data_out_c holds its value. ACTIVE persists until reset.
REQ-022 Known limitation: a data word equal to IDLE is consumed as idle and not delivered.
REQ-023 Latency: valid_out_c is asserted BITS+1 cycles after the accept edge (loopback, ACTIVE); this is 17 cycles for 32/2.
REQ-024 Back-to-back words: one word per BITS cycles, with no gaps and no loss.
REQ-025 rx_active = 1 exactly when the FSM is in ACTIVE.

Reset
REQ-026 Assertion (reset=0) immediately clears all of the following:
  - Data_out_lanes=0, ready_out=0, valid_out_c=0, Data_out_c=0, rx_active=0.
  - Counters cleared, FSM set to SYNC.
REQ-027 Mid-word reset discards the in-flight word, and no partial word is ever output.
REQ-028 After deassertion, the first slot starts with the counter at 0, and tx sends IDLE until the first transfer.

Configuration
REQ-029 Macro PHY_LOOPBACK_EN defined: rx inputs connect internally to the tx lane registers, Data_in_lanes is ignored, and Data_out_lanes is still driven.
REQ-030 PHY_LOOPBACK_EN undefined: rx uses Data_in_lanes, and no internal path exists from tx to rx.

Verification
REQ-031 Loopback, defaults, reset released, valid_in=0 -> rx_active=1 within (SYNC_N+2)*BITS=96 cycles; valid_out_c stays 0.
REQ-032 Once active, one transfer of 32'hDEADBEEF -> valid_out_c pulses once, 17 cycles after the accept edge, with Data_out_c=32'hDEADBEEF.
REQ-033 valid_in held high with words 1,2,3,4 at consecutive ready_out pulses -> four pulses spaced 16 cycles apart, carrying 1,2,3,4 in order.
REQ-034 Data_in=32'hBCBCBCBC transferred -> no valid_out_c pulse.
REQ-035 reset pulsed low mid-word -> all outputs 0 at once; after release, rx re-locks per REQ-031 with no spurious pulse.
REQ-036 External mode, rx lanes fed a word-shifted IDLE stream with a bit offset of 5 -> lock acquired; data sent after lock is recovered correctly.
